// File: rtl/bsnn_layer_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : bsnn_layer_sequencer
// Description : Time-multiplexed binary SNN inference engine. A shared
//               popcount/threshold datapath evaluates NUM_LAYERS binary
//               layers, PAR neurons per cycle, with weights streamed from
//               an external 1-cycle-latency synchronous memory.
// Revision    : 1.0 - initial release
// ============================================================================
module bsnn_layer_sequencer #(
  parameter int IN_WIDTH   = 256,
  parameter int N_NEURONS  = 256,
  parameter int NUM_LAYERS = 6,
  parameter int PAR        = 16,
  parameter int THRESHOLD  = 128,
  parameter int XNOR_MODE  = 0,
  localparam int ROW_W = (IN_WIDTH > N_NEURONS) ? IN_WIDTH : N_NEURONS,
  localparam int G     = N_NEURONS / PAR,
  localparam int CW    = $clog2(ROW_W + 1),
  localparam int AW    = ($clog2(NUM_LAYERS * G) < 1) ? 1 : $clog2(NUM_LAYERS * G),
  localparam int LW    = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  input_row,
  output logic                 w_rd_en,
  output logic [AW-1:0]        w_rd_addr,
  input  logic [PAR*ROW_W-1:0] w_rd_data,
  input  logic                 cfg_we,
  input  logic [LW-1:0]        cfg_layer,
  input  logic [CW-1:0]        cfg_threshold,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N_NEURONS-1:0] final_spike_vector,
  output logic                 busy
);

  // Group counter must hold 0..G (G itself marks the drain cycle).
  localparam int GW = $clog2(G + 1);

  // Fan-in masks: layer 0 sees IN_WIDTH inputs, later layers N_NEURONS.
  localparam logic [ROW_W-1:0] c_mask_in = {ROW_W{1'b1}} >> (ROW_W - IN_WIDTH);
  localparam logic [ROW_W-1:0] c_mask_n  = {ROW_W{1'b1}} >> (ROW_W - N_NEURONS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [ROW_W-1:0]     r_act;
  logic [N_NEURONS-1:0] r_next;
  logic [N_NEURONS-1:0] r_final;
  logic [LW-1:0]        r_layer;
  logic [GW-1:0]        r_group;
  logic                 r_rd_valid;
  logic [GW-1:0]        r_rd_group;
  logic [CW-1:0]        r_thr [NUM_LAYERS];

  logic                 w_drain;
  logic                 w_last_layer;
  logic                 w_cfg_ok;
  logic [ROW_W-1:0]     w_mask;
  logic [CW-1:0]        w_thr;
  logic [ROW_W-1:0]     w_row;
  logic [ROW_W-1:0]     w_bits;
  logic [CW-1:0]        w_cnt;
  logic [PAR-1:0]       w_spikes;
  logic [N_NEURONS-1:0] w_next_merged;

  assign w_drain      = (r_state == S_RUN) && (r_group == GW'(G));
  assign w_last_layer = (r_layer == LW'(NUM_LAYERS - 1));
  assign w_cfg_ok     = (32'(cfg_layer) < 32'(NUM_LAYERS));
  assign w_mask       = (r_layer == '0) ? c_mask_in : c_mask_n;
  assign w_thr        = r_thr[r_layer];
  assign w_rd_addr    = w_rd_en ? AW'(int'(r_layer) * G + int'(r_group)) : '0;
  assign final_spike_vector = r_final;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake/strobe outputs.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    w_rd_en     = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        busy    = 1'b1;
        w_rd_en = !w_drain;
        if (w_drain && w_last_layer) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Per-neuron popcount over the active fan-in and threshold compare for
  // the weight word returned this cycle.
  always_comb begin
    w_spikes = '0;
    w_row    = '0;
    w_bits   = '0;
    w_cnt    = '0;
    for (int p = 0; p < PAR; p++) begin
      w_row = w_rd_data[p*ROW_W +: ROW_W];
      if (XNOR_MODE != 0) begin
        w_bits = ~(r_act ^ w_row);
      end else begin
        w_bits = r_act & w_row;
      end
      w_bits = w_bits & w_mask;
      w_cnt  = '0;
      for (int k = 0; k < ROW_W; k++) begin
        w_cnt = w_cnt + CW'(w_bits[k]);
      end
      w_spikes[p] = (w_cnt >= w_thr);
    end
  end

  // Next-activation including the group whose weights arrive this cycle;
  // the last group of a layer lands in the drain cycle.
  always_comb begin
    w_next_merged = r_next;
    if (r_rd_valid) begin
      w_next_merged[int'(r_rd_group)*PAR +: PAR] = w_spikes;
    end
  end

  // Datapath: activation, layer/group counters, read tracking, thresholds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_act      <= '0;
      r_next     <= '0;
      r_final    <= '0;
      r_layer    <= '0;
      r_group    <= '0;
      r_rd_valid <= 1'b0;
      r_rd_group <= '0;
      for (int i = 0; i < NUM_LAYERS; i++) begin
        r_thr[i] <= CW'(THRESHOLD);
      end
    end else begin
      // Remember which group the in-flight read belongs to.
      r_rd_valid <= w_rd_en;
      r_rd_group <= r_group;

      // Thresholds are only writable while idle, so a write in the same
      // cycle as input acceptance applies to that input.
      if ((r_state == S_IDLE) && cfg_we && w_cfg_ok) begin
        r_thr[cfg_layer] <= cfg_threshold;
      end

      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_act                 <= '0;
            r_act[IN_WIDTH-1:0]   <= input_row;
            r_next                <= '0;
            r_layer               <= '0;
            r_group               <= '0;
          end
        end
        S_RUN: begin
          if (w_drain) begin
            r_act                 <= '0;
            r_act[N_NEURONS-1:0]  <= w_next_merged;
            r_next                <= '0;
            r_group               <= '0;
            if (w_last_layer) begin
              r_final <= w_next_merged;
              r_layer <= '0;
            end else begin
              r_layer <= r_layer + 1'b1;
            end
          end else begin
            r_next  <= w_next_merged;
            r_group <= r_group + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bsnn_layer_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_bsnn_layer_sequencer
// Description : Scoreboard bench for bsnn_layer_sequencer. Two instances
//               (AND mode and XNOR mode) share a weight table and clock.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bsnn_layer_sequencer;

  localparam int NL   = 2;
  localparam int NN   = 8;
  localparam int THR0 = 4;
  localparam int LAT  = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid [2];
  logic        in_ready [2];
  logic [7:0]  input_row [2];
  logic        w_rd_en [2];
  logic [1:0]  rd_addr [2];
  logic [31:0] rd_data [2];
  logic        cfg_we [2];
  logic        cfg_layer [2];
  logic [3:0]  cfg_thr [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [7:0]  final_vec [2];
  logic        busy [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    bsnn_layer_sequencer #(
      .IN_WIDTH(8), .N_NEURONS(8), .NUM_LAYERS(2), .PAR(4),
      .THRESHOLD(THR0), .XNOR_MODE(gi)
    ) u_dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[gi]), .in_ready(in_ready[gi]), .input_row(input_row[gi]),
      .w_rd_en(w_rd_en[gi]), .w_rd_addr(rd_addr[gi]), .w_rd_data(rd_data[gi]),
      .cfg_we(cfg_we[gi]), .cfg_layer(cfg_layer[gi]), .cfg_threshold(cfg_thr[gi]),
      .out_valid(out_valid[gi]), .out_ready(out_ready[gi]),
      .final_spike_vector(final_vec[gi]), .busy(busy[gi])
    );
  end

  // Weight table: wrow[layer][neuron], bit k pairs with activation bit k.
  logic [7:0] wrow [NL][NN];
  logic [3:0] thr_m [2][NL];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int exp_addr [2];
  logic prev_ov [2];

  typedef struct {
    int         inst;
    logic [7:0] vec;
    int         acc;
  } exp_t;
  exp_t exp_q [$];
  exp_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [1:0] a);
    logic [31:0] w;
    int l, g;
    l = int'(a) / 2;
    g = int'(a) % 2;
    for (int p = 0; p < 4; p++) w[p*8 +: 8] = wrow[l][g*4 + p];
    return w;
  endfunction

  // 1-cycle-latency synchronous weight memory per instance.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (w_rd_en[i]) rd_data[i] <= mem_word(rd_addr[i]);
    end
  end

  // Reference: layer-by-layer neuron evaluation with plain popcounts.
  function automatic logic [7:0] model(input int xn, input logic [7:0] row,
                                       input logic [3:0] t0, input logic [3:0] t1);
    logic [7:0] act, nxt, bits;
    int t;
    act = row;
    for (int l = 0; l < NL; l++) begin
      t = (l == 0) ? int'(t0) : int'(t1);
      for (int n = 0; n < NN; n++) begin
        bits   = (xn != 0) ? ~(act ^ wrow[l][n]) : (act & wrow[l][n]);
        nxt[n] = ($countones(bits) >= t);
      end
      act = nxt;
    end
    return act;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: address sequence and result scoreboard.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst && w_rd_en[i]) begin
        check($sformatf("rd_addr%0d", i), 32'(rd_addr[i]), 32'(exp_addr[i]));
        exp_addr[i]++;
      end
      if (out_valid[i] && !prev_ov[i]) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out inst=%0d got 0x%0h expected none", i, final_vec[i]);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_inst", 32'(i), 32'(mon_e.inst));
          check($sformatf("out_vec%0d", i), 32'(final_vec[i]), 32'(mon_e.vec));
          check("out_latency", 32'(cyc - mon_e.acc), 32'(LAT));
        end
      end
      prev_ov[i] = out_valid[i];
    end
  end

  task automatic cfg(input int inst, input int layer, input int val);
    @(posedge clk); #1;
    cfg_we[inst] = 1'b1; cfg_layer[inst] = layer[0]; cfg_thr[inst] = val[3:0];
    @(posedge clk); #1;
    cfg_we[inst] = 1'b0;
    thr_m[inst][layer] = val[3:0];
  endtask

  task automatic submit(input int inst, input logic [7:0] row,
                        input bit do_cfg, input int cl, input int cv);
    int n;
    n = 0;
    @(posedge clk); #1;
    while (!in_ready[inst] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("submit_ready_timeout", 32'(in_ready[inst]), 32'd1);
    in_valid[inst] = 1'b1;
    input_row[inst] = row;
    if (do_cfg) begin
      cfg_we[inst] = 1'b1; cfg_layer[inst] = cl[0]; cfg_thr[inst] = cv[3:0];
      thr_m[inst][cl] = cv[3:0];
    end
    exp_addr[inst] = 0;
    @(posedge clk); #1;
    in_valid[inst] = 1'b0;
    cfg_we[inst] = 1'b0;
    exp_q.push_back('{inst: inst, vec: model(inst, row, thr_m[inst][0], thr_m[inst][1]), acc: cyc});
  endtask

  task automatic wait_done(input int inst);
    int n;
    n = 0;
    while (!out_valid[inst] && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", 32'(out_valid[inst]), 32'd1);
    @(posedge clk); #1;
    check("in_ready_after_hs", 32'(in_ready[inst]), 32'd1);
  endtask

  task automatic run(input int inst, input logic [7:0] row);
    submit(inst, row, 1'b0, 0, 0);
    wait_done(inst);
  endtask

  task automatic check_reset_outputs(input int inst);
    check("rst_in_ready", 32'(in_ready[inst]), 32'd1);
    check("rst_out_valid", 32'(out_valid[inst]), 32'd0);
    check("rst_busy", 32'(busy[inst]), 32'd0);
    check("rst_w_rd_en", 32'(w_rd_en[inst]), 32'd0);
    check("rst_w_rd_addr", 32'(rd_addr[inst]), 32'd0);
    check("rst_final", 32'(final_vec[inst]), 32'd0);
  endtask

  task automatic set_weights(input int kind);
    for (int l = 0; l < NL; l++)
      for (int n = 0; n < NN; n++)
        case (kind)
          0: wrow[l][n] = 8'h00;
          1: wrow[l][n] = 8'hFF;
          2: wrow[l][n] = 8'(1 << n);
          default: wrow[l][n] = 8'($urandom);
        endcase
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] hold_exp;
    logic [7:0] r;
    int inst;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 0; input_row[i] = 0; cfg_we[i] = 0; cfg_layer[i] = 0;
      cfg_thr[i] = 0; out_ready[i] = 1; exp_addr[i] = 0; prev_ov[i] = 0;
      thr_m[i][0] = THR0; thr_m[i][1] = THR0;
    end
    set_weights(0);
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) check_reset_outputs(i);
    rst = 1'b0;

    // All-ones weights, default thresholds, AND mode.
    set_weights(1);
    run(0, 8'hFF);

    // Identity weights, thresholds 1.
    set_weights(2);
    cfg(0, 0, 1);
    cfg(0, 1, 1);
    run(0, 8'h0F);
    run(0, 8'h00);

    // Threshold above fan-in, then threshold 0.
    cfg(0, 1, 9);
    run(0, 8'hFF);
    cfg(0, 1, 0);
    run(0, 8'hFF);

    // Config write in the same cycle as acceptance applies to that input.
    submit(0, 8'h3C, 1'b1, 1, 9);
    wait_done(0);
    cfg(0, 1, 1);

    // Back-pressure: hold result, ignore competing input and cfg writes.
    out_ready[0] = 1'b0;
    hold_exp = model(0, 8'hA5, thr_m[0][0], thr_m[0][1]);
    submit(0, 8'hA5, 1'b0, 0, 0);
    for (int n = 0; n < 40 && !out_valid[0]; n++) @(negedge clk);
    @(posedge clk); #1;
    in_valid[0] = 1'b1; input_row[0] = 8'h5A;
    cfg_we[0] = 1'b1; cfg_layer[0] = 1'b1; cfg_thr[0] = 4'd15;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      check("hold_vec", 32'(final_vec[0]), 32'(hold_exp));
      check("hold_in_ready", 32'(in_ready[0]), 32'd0);
      check("hold_out_valid", 32'(out_valid[0]), 32'd1);
    end
    @(posedge clk); #1;
    in_valid[0] = 1'b0; cfg_we[0] = 1'b0; out_ready[0] = 1'b1;
    @(posedge clk); #1;
    check("release_in_ready", 32'(in_ready[0]), 32'd1);
    check("release_busy", 32'(busy[0]), 32'd0);
    run(0, 8'hC3);

    // Reset during the first layer-1 issue cycle.
    cfg(0, 0, 9);
    cfg(0, 1, 9);
    set_weights(1);
    submit(0, 8'h0F, 1'b0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_rd_en", 32'(w_rd_en[0]), 32'd1);
    rst = 1'b1;
    void'(exp_q.pop_back());
    thr_m[0][0] = THR0; thr_m[0][1] = THR0;
    @(posedge clk); #1;
    check_reset_outputs(0);
    rst = 1'b0;
    run(0, 8'h0F);

    // XNOR instance: all-zero weights, thresholds at full fan-in.
    set_weights(0);
    cfg(1, 0, 8);
    cfg(1, 1, 8);
    run(1, 8'h00);
    run(1, 8'h01);

    // Randomized runs on both instances.
    for (int it = 0; it < 16; it++) begin
      inst = int'($urandom_range(1, 0));
      set_weights(3);
      r = 8'($urandom);
      cfg(inst, 0, int'($urandom_range(9, 0)));
      if ($urandom_range(1, 0) == 0) begin
        submit(inst, r, 1'b1, 1, int'($urandom_range(9, 0)));
      end else begin
        cfg(inst, 1, int'($urandom_range(9, 0)));
        submit(inst, r, 1'b0, 0, 0);
      end
      wait_done(inst);
    end

    repeat (5) @(posedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
